// File: rtl/key_event_decoder_pkg.sv
// rtl/key_event_decoder_pkg.sv - shared state encoding and timing helpers for key consumers
//
// Purpose : FSM state encoding for the gesture decoder and the microsecond to
//           sysclk-cycle conversion used to size the hold and gap timers.
// Contents: key_state_t, us_to_cyc(), max_int()
package key_event_decoder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PRESS1 = 3'd1,
      ST_WAIT2  = 3'd2,
      ST_PRESS2 = 3'd3,
      ST_HELD   = 3'd4
   } key_state_t;

   // Widened to 64 bits so large microsecond values do not overflow before the divide.
   function automatic int us_to_cyc(input int us, input int clk_ns);
      return int'((longint'(us) * 64'sd1000) / longint'(clk_ns));
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_edge.sv
// rtl/key_edge.sv - key level delay, press/release edge detect and held-level register
//
// Purpose : Turns a clean active-low key level into edge strobes and registered
//           edge pulses. Reusable by any key consumer.
// Ports   : sysclk        in  system clock, rising edge
//           rst_n         in  synchronous active-low reset
//           key_in        in  debounced key level, 0 = pressed
//           press_edge    out combinational press strobe (key_d=1, key_in=0)
//           release_edge  out combinational release strobe (key_d=0, key_in=1)
//           key_pressed   out registered level, 1 while the key is held
//           press_pulse   out registered one-cycle pulse per press edge
//           release_pulse out registered one-cycle pulse per release edge
module key_edge (
   input  logic sysclk,
   input  logic rst_n,
   input  logic key_in,
   output logic press_edge,
   output logic release_edge,
   output logic key_pressed,
   output logic press_pulse,
   output logic release_pulse
);

   logic key_d;

   // key_d resets to "released" so a key held low across reset still yields a press.
   assign press_edge   = key_d & ~key_in;
   assign release_edge = ~key_d & key_in;

   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         key_d         <= 1'b1;
         key_pressed   <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         key_d         <= key_in;
         key_pressed   <= ~key_in;
         press_pulse   <= press_edge;
         release_pulse <= release_edge;
      end
   end

endmodule

// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - classifies debounced key gestures into event pulses
//
// Purpose : Produces press/release pulses on every edge and gesture pulses for
//           click, double-click and long-press from a debounced key level.
// Ports   : sysclk        in  system clock, rising edge
//           rst_n         in  synchronous active-low reset
//           key_in        in  debounced key level, 1 = released, 0 = pressed
//           key_pressed   out registered level, 1 while the key is held
//           press_pulse   out one-cycle pulse per press edge
//           release_pulse out one-cycle pulse per release edge
//           click         out one-cycle pulse for a lone short press
//           double_click  out one-cycle pulse at the second release of a double-click
//           long_press    out one-cycle pulse when a hold reaches LONG_CYC cycles
module key_event_decoder
   import key_event_decoder_pkg::*;
#(
   parameter int CLK_CYC   = 10,
   parameter int LONG_US   = 1_000_000,
   parameter int DCLICK_US = 300_000
) (
   input  logic sysclk,
   input  logic rst_n,
   input  logic key_in,
   output logic key_pressed,
   output logic press_pulse,
   output logic release_pulse,
   output logic click,
   output logic double_click,
   output logic long_press
);

   localparam int LONG_CYC   = us_to_cyc(LONG_US, CLK_CYC);
   localparam int DCLICK_CYC = us_to_cyc(DCLICK_US, CLK_CYC);
   localparam int CNT_W      = $clog2(max_int(LONG_CYC, DCLICK_CYC)) + 1;

   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYC - 1);

   logic             press_edge;
   logic             release_edge;
   key_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;

   key_edge u_key_edge (
      .sysclk        (sysclk),
      .rst_n         (rst_n),
      .key_in        (key_in),
      .press_edge    (press_edge),
      .release_edge  (release_edge),
      .key_pressed   (key_pressed),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse)
   );

   // Saturating increment: the timer holds at all-ones instead of wrapping.
   assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

   // Edge checks come before the timer checks in every branch, so an edge that
   // lands on the final timer cycle takes priority over the timeout.
   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         click        <= 1'b0;
         double_click <= 1'b0;
         long_press   <= 1'b0;
      end else begin
         click        <= 1'b0;
         double_click <= 1'b0;
         long_press   <= 1'b0;
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (press_edge) begin
                  state <= ST_PRESS1;
               end
            end
            ST_PRESS1: begin
               if (release_edge) begin
                  state <= ST_WAIT2;
                  cnt   <= '0;
               end else if (cnt == LONG_LAST) begin
                  long_press <= 1'b1;
                  state      <= ST_HELD;
                  cnt        <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            ST_WAIT2: begin
               if (press_edge) begin
                  state <= ST_PRESS2;
                  cnt   <= '0;
               end else if (cnt == DCLICK_LAST) begin
                  click <= 1'b1;
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            ST_PRESS2: begin
               if (release_edge) begin
                  double_click <= 1'b1;
                  state        <= ST_IDLE;
                  cnt          <= '0;
               end else if (cnt == LONG_LAST) begin
                  long_press <= 1'b1;
                  state      <= ST_HELD;
                  cnt        <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            ST_HELD: begin
               cnt <= '0;
               if (release_edge) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
